// File: rtl/rv32i_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rv32i_pkg                                              |
// | Description : Shared opcodes, FSM state encoding and datapath select |
// |               encodings for the multicycle RV32I controller.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package rv32i_pkg;

    // Base opcodes (IR[6:0])
    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

    // Controller states
    typedef enum logic [2:0] {
        S_BOOT      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    // PC source
    localparam logic [1:0] c_PC_PLUS4    = 2'd0;
    localparam logic [1:0] c_PC_ALU      = 2'd1;
    localparam logic [1:0] c_PC_ALU_JALR = 2'd2;

    // ALU operand selects
    localparam logic [1:0] c_ALU_A_RS1  = 2'd0;
    localparam logic [1:0] c_ALU_A_PC   = 2'd1;
    localparam logic [1:0] c_ALU_A_ZERO = 2'd2;
    localparam logic [1:0] c_ALU_B_RS2  = 2'd0;
    localparam logic [1:0] c_ALU_B_IMM  = 2'd1;
    localparam logic [1:0] c_ALU_B_FOUR = 2'd2;

    // Writeback source
    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC4 = 2'd2;

    // Trap causes
    localparam logic [1:0] c_TRAP_NONE    = 2'd0;
    localparam logic [1:0] c_TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] c_TRAP_TIMEOUT = 2'd2;
    localparam logic [1:0] c_TRAP_ENV     = 2'd3;

    localparam logic [3:0]  c_ALU_ADD = 4'b0000;
    localparam logic [31:0] c_NOP     = 32'h0000_0013;

    // True for every opcode the core executes (SYSTEM is handled separately)
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        case (opc)
            c_OPC_LUI, c_OPC_AUIPC, c_OPC_JAL, c_OPC_JALR, c_OPC_BRANCH,
            c_OPC_LOAD, c_OPC_STORE, c_OPC_OP_IMM, c_OPC_OP,
            c_OPC_MISC_MEM: is_legal_opcode = 1'b1;
            default:        is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : imm_gen                                                |
// | Description : Combinational I/S/B/U/J immediate extraction from the  |
// |               instruction register, selected by opcode.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_ir,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    // Pick the immediate format implied by the opcode; formats without an immediate yield 0
    always_comb begin
        w_imm32 = '0;
        case (i_ir[6:0])
            c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_JALR:
                w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
            c_OPC_STORE:
                w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
            c_OPC_BRANCH:
                w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
            c_OPC_LUI, c_OPC_AUIPC:
                w_imm32 = {i_ir[31:12], 12'h000};
            c_OPC_JAL:
                w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : multicycle_control                                     |
// | Description : Multicycle RV32I sequencer. Owns the IR and steps each |
// |               instruction through fetch/decode/execute/mem/wb.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module multicycle_control
    import rv32i_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_addr_sel,
    output logic            ir_we,
    output logic            pc_we,
    output logic [1:0]      pc_src,
    output logic [1:0]      alu_a_sel,
    output logic [1:0]      alu_b_sel,
    output logic [3:0]      alu_op,
    output logic [4:0]      reg_1,
    output logic [4:0]      reg_2,
    output logic [4:0]      reg_w,
    output logic            reg_write,
    output logic [1:0]      wb_sel,
    output logic [XLEN-1:0] imm,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    localparam int              c_CW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(MEM_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_ir;
    logic [c_CW-1:0] r_wait;
    logic [1:0]      r_cause;
    logic [1:0]      w_cause;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic       w_is_store;
    logic       w_mem_phase;
    logic       w_timeout;

    assign w_opc       = r_ir[6:0];
    assign w_f3        = r_ir[14:12];
    assign w_is_store  = (w_opc == c_OPC_STORE);
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEMORY);
    // Last permitted wait cycle elapsed with no handshake
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_phase && !mem_ready && (r_wait == c_WAIT_LAST);

    assign reg_1      = r_ir[19:15];
    assign reg_2      = r_ir[24:20];
    assign reg_w      = r_ir[11:7];
    assign trap_cause = r_cause;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_ir  (r_ir),
        .o_imm (imm)
    );

    // State, instruction register, memory wait counter and sticky trap cause
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_BOOT;
            r_ir    <= c_NOP;
            r_wait  <= '0;
            r_cause <= c_TRAP_NONE;
        end else begin
            r_state <= w_next;
            if (ir_we) begin
                r_ir <= mem_rdata;
            end
            if (w_mem_phase && !mem_ready && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if ((r_state != S_TRAP) && (w_next == S_TRAP)) begin
                r_cause <= w_cause;
            end
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        w_next       = r_state;
        w_cause      = c_TRAP_NONE;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = c_PC_PLUS4;
        alu_a_sel    = c_ALU_A_RS1;
        alu_b_sel    = c_ALU_B_RS2;
        alu_op       = c_ALU_ADD;
        reg_write    = 1'b0;
        wb_sel       = c_WB_ALU;
        trap         = 1'b0;

        case (r_state)
            S_BOOT: begin
                w_next = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_cause = c_TRAP_TIMEOUT;
                    w_next  = S_TRAP;
                end
            end

            S_DECODE: begin
                if (r_ir[1:0] != 2'b11) begin
                    w_cause = c_TRAP_ILLEGAL;
                    w_next  = S_TRAP;
                end else if (w_opc == c_OPC_SYSTEM) begin
                    w_cause = c_TRAP_ENV;
                    w_next  = S_TRAP;
                end else if (!is_legal_opcode(w_opc)) begin
                    w_cause = c_TRAP_ILLEGAL;
                    w_next  = S_TRAP;
                end else begin
                    w_next = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                w_next = S_WRITEBACK;
                case (w_opc)
                    c_OPC_OP: begin
                        alu_op = {r_ir[30], w_f3};
                    end
                    c_OPC_OP_IMM: begin
                        alu_b_sel = c_ALU_B_IMM;
                        // Only SRAI distinguishes on funct7[5]; other I-type ops carry immediate bits there
                        alu_op    = {(w_f3 == 3'b101) & r_ir[30], w_f3};
                    end
                    c_OPC_LOAD, c_OPC_STORE: begin
                        alu_b_sel = c_ALU_B_IMM;
                        w_next    = S_MEMORY;
                    end
                    c_OPC_JALR: begin
                        alu_b_sel = c_ALU_B_IMM;
                    end
                    c_OPC_AUIPC, c_OPC_JAL: begin
                        alu_a_sel = c_ALU_A_PC;
                        alu_b_sel = c_ALU_B_IMM;
                    end
                    c_OPC_BRANCH: begin
                        alu_a_sel = c_ALU_A_PC;
                        alu_b_sel = c_ALU_B_IMM;
                        pc_we     = 1'b1;
                        pc_src    = branch_taken ? c_PC_ALU : c_PC_PLUS4;
                        w_next    = S_FETCH;
                    end
                    c_OPC_LUI: begin
                        alu_a_sel = c_ALU_A_ZERO;
                        alu_b_sel = c_ALU_B_IMM;
                    end
                    c_OPC_MISC_MEM: begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end
                    default: begin
                        w_next = S_WRITEBACK;
                    end
                endcase
            end

            S_MEMORY: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_store;
                if (mem_ready) begin
                    if (w_is_store) begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end else if (w_timeout) begin
                    w_cause = c_TRAP_TIMEOUT;
                    w_next  = S_TRAP;
                end
            end

            S_WRITEBACK: begin
                // Register file has no storage for x0, so never strobe it
                reg_write = (r_ir[11:7] != 5'd0);
                pc_we     = 1'b1;
                w_next    = S_FETCH;
                case (w_opc)
                    c_OPC_LOAD: wb_sel = c_WB_MEM;
                    c_OPC_JAL: begin
                        wb_sel = c_WB_PC4;
                        pc_src = c_PC_ALU;
                    end
                    c_OPC_JALR: begin
                        wb_sel = c_WB_PC4;
                        pc_src = c_PC_ALU_JALR;
                    end
                    default: wb_sel = c_WB_ALU;
                endcase
            end

            S_TRAP: begin
                trap = 1'b1;
            end

            default: begin
                w_next = S_BOOT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_multicycle_control                                  |
// | Description : Randomized self-checking bench for multicycle_control  |
// |               against an instruction-level reference of its phases.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_write, trap;
    logic [1:0]  pc_src, alu_a_sel, alu_b_sel, wb_sel, trap_cause;
    logic [3:0]  alu_op;
    logic [4:0]  reg_1, reg_2, reg_w;
    logic [31:0] imm;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0]  legal_ops [10];
    logic [35:0] all_outs;
    logic [5:0]  strobes;

    assign all_outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
                       alu_op, reg_1, reg_2, reg_w, reg_write, wb_sel, trap, trap_cause};
    assign strobes  = {mem_req, mem_we, ir_we, pc_we, reg_write, trap};

    always #5 clock = ~clock;

    multicycle_control #(
        .XLEN        (32),
        .MEM_TIMEOUT (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op       (alu_op),
        .reg_1        (reg_1),
        .reg_2        (reg_2),
        .reg_w        (reg_w),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .imm          (imm),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference immediate built from the ISA field definitions
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic signed [31:0] s;
        logic [31:0]        r;
        s = ins;
        r = '0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: r = s >>> 20;
            7'h23: begin r = s >>> 20; r[4:0] = ins[11:7]; end
            7'h63: begin r = (s >>> 31) << 12; r[11] = ins[7]; r[10:5] = ins[30:25]; r[4:1] = ins[11:8]; r[0] = 1'b0; end
            7'h37, 7'h17: r = ins & 32'hFFFF_F000;
            7'h6F: begin r = (s >>> 31) << 20; r[19:12] = ins[19:12]; r[11] = ins[20]; r[10:1] = ins[30:21]; r[0] = 1'b0; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Expected {alu_a_sel, alu_b_sel} in EXECUTE; F means the class does not define them
    function automatic logic [3:0] ref_sel(input logic [6:0] op);
        case (op)
            7'h33:               return 4'b0000;
            7'h13, 7'h03, 7'h23, 7'h67: return 4'b0001;
            7'h17, 7'h6F, 7'h63: return 4'b0101;
            7'h37:               return 4'b1001;
            default:             return 4'hF;
        endcase
    endfunction

    task automatic step(input string tag, input logic rdy, input logic tk, input logic [5:0] exp);
        @(negedge clock);
        mem_ready    = rdy;
        branch_taken = tk;
        #1;
        chk(tag, {58'd0, strobes}, {58'd0, exp});
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One complete legal instruction with fw fetch waits and mw memory waits
    task automatic do_instr(input logic [31:0] instr, input int fw, input int mw);
        logic [6:0] op;
        logic [4:0] rd;
        logic       tk, st;
        logic [3:0] sel;
        op = instr[6:0];
        rd = instr[11:7];
        mem_rdata = instr;
        for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, rbit(), 6'b100000);
        step("fetch", 1'b1, rbit(), 6'b101000);
        step("decode", rbit(), rbit(), 6'b000000);
        chk("reg_1", {59'd0, reg_1}, {59'd0, instr[19:15]});
        chk("reg_2", {59'd0, reg_2}, {59'd0, instr[24:20]});
        if (op != 7'h33 && op != 7'h0F) chk("imm", {32'd0, imm}, {32'd0, ref_imm(instr)});
        tk = rbit();
        if (op == 7'h63 || op == 7'h0F) begin
            step("exec_pc", rbit(), tk, 6'b000100);
            chk("exec_pc_src", {62'd0, pc_src}, (op == 7'h63 && tk) ? 64'd1 : 64'd0);
        end else begin
            step("exec", rbit(), tk, 6'b000000);
        end
        sel = ref_sel(op);
        if (sel != 4'hF) chk("alu_sel", {60'd0, alu_a_sel, alu_b_sel}, {60'd0, sel});
        if (op == 7'h33) chk("alu_op", {60'd0, alu_op}, {60'd0, instr[30], instr[14:12]});
        if (op == 7'h13) chk("alu_op", {60'd0, alu_op}, {60'd0, (instr[14:12] == 3'b101) ? instr[30] : 1'b0, instr[14:12]});
        if (op == 7'h03 || op == 7'h23 || op == 7'h37 || op == 7'h17) chk("alu_op_add", {60'd0, alu_op}, 64'd0);
        if (op == 7'h03 || op == 7'h23) begin
            st = (op == 7'h23);
            for (int i = 0; i < mw; i++) begin
                step("mem_wait", 1'b0, rbit(), {1'b1, st, 4'b0000});
                chk("mem_addr_sel", {63'd0, mem_addr_sel}, 64'd1);
            end
            step("mem", 1'b1, rbit(), {1'b1, st, 1'b0, st, 2'b00});
            chk("mem_addr_sel", {63'd0, mem_addr_sel}, 64'd1);
            if (st) chk("store_pc_src", {62'd0, pc_src}, 64'd0);
        end
        if (op != 7'h63 && op != 7'h0F && op != 7'h23) begin
            step("wb", rbit(), rbit(), {3'b000, 1'b1, (rd != 5'd0), 1'b0});
            chk("reg_w", {59'd0, reg_w}, {59'd0, rd});
            chk("wb_sel", {62'd0, wb_sel}, (op == 7'h03) ? 64'd1 : (op == 7'h6F || op == 7'h67) ? 64'd2 : 64'd0);
            chk("wb_pc_src", {62'd0, pc_src}, (op == 7'h6F) ? 64'd1 : (op == 7'h67) ? 64'd2 : 64'd0);
        end
    endtask

    // Assert reset asynchronously, confirm all outputs drop without a clock edge, then release
    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_async_outs"}, {28'd0, all_outs}, 64'd0);
        chk({tag, "_async_imm"}, {32'd0, imm}, 64'd0);
        @(negedge clock);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk({tag, "_boot_outs"}, {28'd0, all_outs}, 64'd0);
    endtask

    // Fetch an instruction that must trap in DECODE with the given cause
    task automatic do_trap(input logic [31:0] instr, input logic [1:0] cause, input int pulses);
        mem_rdata = instr;
        step("trap_fetch", 1'b1, 1'b0, 6'b101000);
        step("trap_decode", 1'b0, 1'b0, 6'b000000);
        step("trap_enter", 1'b0, 1'b0, 6'b000001);
        chk("trap_cause", {62'd0, trap_cause}, {62'd0, cause});
        for (int i = 0; i < pulses; i++) step("trap_hold", rbit(), rbit(), 6'b000001);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        legal_ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
        reset        = 1'b0;
        mem_ready    = 1'b0;
        mem_rdata    = 32'd0;
        branch_taken = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_outs", {28'd0, all_outs}, 64'd0);
        chk("reset_imm", {32'd0, imm}, 64'd0);
        @(negedge clock);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("boot_outs", {28'd0, all_outs}, 64'd0);

        // Directed instructions
        do_instr(32'h0050_0093, 0, 0);   // ADDI x1,x0,5
        do_instr(32'h0010_0013, 0, 0);   // ADDI x0,x0,1
        do_instr(32'h0020_8463, 0, 0);   // BEQ x1,x2,+8
        do_instr(32'h0040_A183, 0, 3);   // LW x3,4(x1), three memory waits
        do_instr(32'h0000_000F, 3, 0);   // FENCE, three fetch waits (last legal wait)

        // Random legal stream
        for (int n = 0; n < 60; n++) begin
            ins      = $urandom;
            ins[6:0] = legal_ops[$urandom_range(0, 9)];
            do_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Illegal opcode, then trap must ignore further traffic
        do_trap(32'hFFFF_FFFF, 2'd1, 10);
        do_reset("illegal");
        do_trap(32'h0000_0073, 2'd3, 2);        // ECALL
        do_reset("ecall");
        do_trap(32'h0050_0090, 2'd1, 2);        // low bits not 2'b11
        do_reset("lowbits");

        // Fetch timeout: four idle fetch cycles then trap
        for (int i = 0; i < 4; i++) step("to_fetch", 1'b0, 1'b0, 6'b100000);
        step("to_trap", 1'b0, 1'b0, 6'b000001);
        chk("to_cause", {62'd0, trap_cause}, 64'd2);
        step("to_hold", 1'b1, 1'b0, 6'b000001);
        do_reset("timeout");

        // Reset in the middle of a memory access
        mem_rdata = 32'h0040_A183;
        step("rm_fetch", 1'b1, 1'b0, 6'b101000);
        step("rm_decode", 1'b0, 1'b0, 6'b000000);
        step("rm_exec", 1'b0, 1'b0, 6'b000000);
        step("rm_mem", 1'b0, 1'b0, 6'b100000);
        reset = 1'b0;
        #1;
        chk("rm_req_drop", {63'd0, mem_req}, 64'd0);
        chk("rm_outs", {28'd0, all_outs}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
